// File: rtl/motor_step_driver_if.sv
// ============================================================================
// Module      : motor_step_driver_if
// Description : Command/status bundle between the input stage and the step driver.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface motor_step_driver_if;
  logic [5:0]  Motor;
  logic [11:0] Value;
  logic [5:0]  Step;
  logic        Busy;
  logic        Done;
  logic        Err;
  logic [9:0]  Remain;
`ifdef HOLD_TORQUE_EN
  logic [5:0]  Hold;

  modport master (output Motor, Value, input Step, Busy, Done, Err, Remain, Hold);
  modport slave  (input Motor, Value, output Step, Busy, Done, Err, Remain, Hold);
`else
  modport master (output Motor, Value, input Step, Busy, Done, Err, Remain);
  modport slave  (input Motor, Value, output Step, Busy, Done, Err, Remain);
`endif
endinterface

`default_nettype wire

// File: rtl/motor_step_driver.sv
// ============================================================================
// Module      : motor_step_driver
// Description : Turns a one-hot motor select and a BCD step count into a step
//               pulse train. Optional macro HOLD_TORQUE_EN adds the Hold output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module motor_step_driver #(
  parameter int HALF_PERIOD = 25000,
  parameter int CNT_W       = 16
) (
  input  wire logic          sysclk,
  input  wire logic          rst,
  motor_step_driver_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_STEP_HI = 3'd2,
    S_STEP_LO = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] c_half_last = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  function automatic logic [9:0] bcd_to_bin(input logic [11:0] v);
    logic [9:0] h, t, u;
    h = {6'd0, v[11:8]};
    t = {6'd0, v[7:4]};
    u = {6'd0, v[3:0]};
    return (h << 6) + (h << 5) + (h << 2) + (t << 3) + (t << 1) + u;
  endfunction

  state_t           state_q;
  logic [17:0]      cmd_prev_q;
  logic [5:0]       ld_motor_q;
  logic [11:0]      ld_value_q;
  logic [5:0]       pend_motor_q;
  logic [11:0]      pend_value_q;
  logic             pend_valid_q;
  logic [5:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [5:0]       step_q;
  logic             busy_q;
  logic             done_q;
  logic             err_q;
  logic [9:0]       remain_q;
`ifdef HOLD_TORQUE_EN
  logic [5:0]       hold_q;
`endif

  logic [17:0] cmd;
  logic        motor_onehot;
  logic        digits_ok;
  logic        new_cmd;
  logic        accept;
  logic [9:0]  ld_bin;
  logic [9:0]  remain_dec;
  logic        phase_end;

  assign cmd          = {bus.Motor, bus.Value};
  assign motor_onehot = (bus.Motor != 6'd0) && ((bus.Motor & (bus.Motor - 6'd1)) == 6'd0);
  assign digits_ok    = (bus.Value[11:8] <= 4'd9) && (bus.Value[7:4] <= 4'd9) &&
                        (bus.Value[3:0] <= 4'd9);
  assign new_cmd      = (cmd != cmd_prev_q) && (bus.Motor != 6'd0);
  assign accept       = new_cmd && motor_onehot && digits_ok;
  assign ld_bin       = bcd_to_bin(ld_value_q);
  assign remain_dec   = remain_q - {9'd0, (remain_q != 10'd0)};
  assign phase_end    = (cnt_q == c_half_last);

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cmd_prev_q   <= 18'd0;
      ld_motor_q   <= 6'd0;
      ld_value_q   <= 12'd0;
      pend_motor_q <= 6'd0;
      pend_value_q <= 12'd0;
      pend_valid_q <= 1'b0;
      sel_q        <= 6'd0;
      cnt_q        <= '0;
      step_q       <= 6'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      remain_q     <= 10'd0;
`ifdef HOLD_TORQUE_EN
      hold_q       <= 6'd0;
`endif
    end else begin
      cmd_prev_q <= cmd;
      done_q     <= 1'b0;
      // Any new command re-evaluates Err: rejects set it, accepts clear it.
      if (new_cmd)
        err_q <= !(motor_onehot && digits_ok);

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ld_motor_q <= bus.Motor;
            ld_value_q <= bus.Value;
            busy_q     <= 1'b1;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          sel_q    <= ld_motor_q;
          remain_q <= ld_bin;
          cnt_q    <= '0;
`ifdef HOLD_TORQUE_EN
          hold_q   <= ld_motor_q;
`endif
          if (ld_bin == 10'd0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            step_q  <= ld_motor_q;
            state_q <= S_STEP_HI;
          end
        end
        S_STEP_HI: begin
          if (phase_end) begin
            cnt_q   <= '0;
            step_q  <= 6'd0;
            state_q <= S_STEP_LO;
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        S_STEP_LO: begin
          if (phase_end) begin
            cnt_q    <= '0;
            remain_q <= remain_dec;
            if (remain_dec == 10'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              step_q  <= sel_q;
              state_q <= S_STEP_HI;
            end
          end else begin
            cnt_q <= cnt_q + c_cnt_one;
          end
        end
        S_DONE: begin
          // A command arriving this very cycle is newer than the pending one.
          pend_valid_q <= 1'b0;
          if (accept) begin
            ld_motor_q <= bus.Motor;
            ld_value_q <= bus.Value;
            state_q    <= S_LOAD;
          end else if (pend_valid_q) begin
            ld_motor_q <= pend_motor_q;
            ld_value_q <= pend_value_q;
            state_q    <= S_LOAD;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept && (state_q == S_LOAD || state_q == S_STEP_HI || state_q == S_STEP_LO)) begin
        pend_motor_q <= bus.Motor;
        pend_value_q <= bus.Value;
        pend_valid_q <= 1'b1;
      end
    end
  end

  assign bus.Step   = step_q;
  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Err    = err_q;
  assign bus.Remain = remain_q;
`ifdef HOLD_TORQUE_EN
  assign bus.Hold   = hold_q;
`endif

endmodule

`default_nettype wire
